mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 48 ++++
 rtl/mem_access_ctrl_byte_lane_unit.sv | 57 +++++
 rtl/mem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and opcode decode helpers for mem_access_ctrl.
package mem_access_ctrl_pkg;

    typedef enum logic [5:0] {
        OP_LW  = 6'h01,
        OP_LH  = 6'h02,
        OP_LHU = 6'h03,
        OP_LB  = 6'h04,
        OP_LBU = 6'h05,
        OP_SW  = 6'h09,
        OP_SH  = 6'h0A,
        OP_SB  = 6'h0B
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    function automatic size_e op_size(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:          return SZ_WORD;
            OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
            OP_LB, OP_LBU, OP_SB:  return SZ_BYTE;
            default:               return SZ_NONE;
        endcase
    endfunction

    function automatic logic op_valid(input logic [5:0] op);
        return op_size(op) != SZ_NONE;
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        case (op)
            OP_SW, OP_SH, OP_SB: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// byte_lane_unit: combinational byte-enable generation, store lane placement and load extension.
module byte_lane_unit
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    input  logic [5:0]  ld_op,
    input  logic [3:0]  ld_be,
    input  logic [31:0] rdata_word,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be         = '0;
        wdata_lane = wdata;
        case (op_size(op))
            SZ_WORD: be = 4'b1111;
            SZ_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            default: be = '0;
        endcase
    end

    // Lane selection for loads follows the byte enables already issued on the bus.
    always_comb begin
        case (ld_be)
            4'b0010: byte_v = rdata_word[15:8];
            4'b0100: byte_v = rdata_word[23:16];
            4'b1000: byte_v = rdata_word[31:24];
            default: byte_v = rdata_word[7:0];
        endcase
        half_v = ld_be[2] ? rdata_word[31:16] : rdata_word[15:0];
    end

    always_comb begin
        case (ld_op)
            OP_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  ld_data = {24'd0, byte_v};
            OP_LH:   ld_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  ld_data = {16'd0, half_v};
            default: ld_data = rdata_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-access CPU-to-memory controller with wait timeout.
// Optional macro MISALIGN_EXC_EN rejects misaligned half/word accesses with err.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e      state, state_next;
    logic [7:0]  wait_cnt;
    logic [5:0]  op_q;
    logic        op_ok;
    logic        accept, reject, ack_ok, timeout;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;
    logic [31:0] ld_data;

    byte_lane_unit u_lane (
        .op         (op),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (be_lane),
        .wdata_lane (wdata_lane),
        .ld_op      (op_q),
        .ld_be      (mem_be),
        .rdata_word (mem_rdata),
        .ld_data    (ld_data)
    );

`ifdef MISALIGN_EXC_EN
    logic misalign;

    always_comb begin
        case (op_size(op))
            SZ_HALF: misalign = addr[0];
            SZ_WORD: misalign = |addr[1:0];
            default: misalign = 1'b0;
        endcase
    end

    assign op_ok = op_valid(op) && !misalign;
`else
    assign op_ok = op_valid(op);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Timeout fires on the edge the counter would reach WAIT_MAX, so an ack in
    // that same cycle still wins.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        ack_ok     = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op_ok) begin
                        accept     = 1'b1;
                        state_next = ST_REQ;
                    end else begin
                        reject     = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    ack_ok     = 1'b1;
                    state_next = ST_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= op;
                wait_cnt  <= '0;
                mem_req   <= 1'b1;
                mem_we    <= op_is_store(op);
                mem_addr  <= {addr[31:2], 2'b00};
                mem_be    <= be_lane;
                mem_wdata <= wdata_lane;
                err       <= 1'b0;
            end
            if (reject) err <= 1'b1;
            if (state == ST_REQ && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
            if (ack_ok || timeout) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                err     <= timeout;
            end
            if (ack_ok && !op_is_store(op_q)) rdata <= ld_data;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (built with WAIT_MAX=4).
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    mem_access_ctrl #(.WAIT_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept edge is edge 0; returns in cycle 1 with inputs scrambled.
    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w);
        start = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        step();
        start = 1'b0;
        op    = OP_SB;
        addr  = 32'hFFFF_FFFF;
        wdata = 32'h5555_5555;
    endtask

    // Access acked in the first REQ cycle, with a stray start pulse while busy.
    task automatic run_xfer(input string tag, input logic [5:0] o, input logic [31:0] a,
                            input logic [31:0] w, input logic [31:0] rd,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic exp_we,
                            input logic [31:0] exp_rdata);
        issue(o, a, w);
        check({tag, "_c1_ctl"}, {29'd0, busy, mem_req, mem_we}, {29'd0, 1'b1, 1'b1, exp_we});
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
        if (exp_we) check({tag, "_wdata"}, mem_wdata, exp_wd);
        start     = 1'b1;
        op        = OP_SW;
        addr      = 32'h0;
        mem_rdata = rd;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        check({tag, "_c2_done"}, {29'd0, done, err, mem_req}, {29'd0, 1'b1, 1'b0, 1'b0});
        check({tag, "_rdata"}, rdata, exp_rdata);
        start = 1'b0;
        step();
        check({tag, "_c3_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    int unsigned req_cycles;
    logic        got_done;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        op        = '0;
        addr      = '0;
        wdata     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bus", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
        rst = 1'b0;
        step();

        run_xfer("lb", OP_LB, 32'h0000_1003, 32'h0, 32'h80AA_BBCC,
                 32'h0000_1000, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80);

        // SH with three wait cycles; ack arrives in the last cycle before timeout.
        issue(OP_SH, 32'h0000_2002, 32'h1234_ABCD);
        check("sh_addr", mem_addr, 32'h0000_2000);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        for (int w = 1; w <= 3; w++) begin
            check("sh_wait", {26'd0, done, mem_req, mem_we, 1'b0, mem_be[3:2]},
                  {26'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11});
            if (w == 2) begin
                start = 1'b1;
                op    = OP_LW;
            end
            step();
        end
        start = 1'b0;
        check("sh_c4_be", {28'd0, mem_be}, 32'h0000_000C);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sh_c5_done", {29'd0, done, err, mem_req}, {29'd0, 1'b1, 1'b0, 1'b0});
        check("sh_rdata_kept", rdata, 32'hFFFF_FF80);
        step();
        check("sh_idle", {31'd0, busy}, 32'd0);

        // LW timeout: expect exactly four request cycles then err.
        issue(OP_LW, 32'h0000_0040, 32'h0);
        mem_rdata  = 32'h1111_1111;
        req_cycles = 0;
        got_done   = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (mem_req) req_cycles++;
            if (done) got_done = 1'b1;
            else step();
        end
        check("to_done_seen", {31'd0, got_done}, 32'd1);
        check("to_req_cycles", req_cycles, 32'd4);
        check("to_err", {30'd0, err, mem_req}, {30'd0, 1'b1, 1'b0});
        check("to_rdata_kept", rdata, 32'hFFFF_FF80);
        mem_ack = 1'b1;
        step();
        step();
        check("ack_outside_req", {30'd0, busy, done}, 32'd0);
        mem_ack = 1'b0;

`ifdef MISALIGN_EXC_EN
        issue(OP_LH, 32'h0000_3001, 32'h0);
        check("lh_mis_done", {29'd0, done, err, mem_req}, {29'd0, 1'b1, 1'b1, 1'b0});
        step();
        check("lh_mis_idle", {31'd0, busy}, 32'd0);
`else
        run_xfer("lh_mis", OP_LH, 32'h0000_3001, 32'h0, 32'h1234_F678,
                 32'h0000_3000, 4'b0011, 32'h0, 1'b0, 32'hFFFF_F678);
`endif

        // Reset while an LHU is outstanding, then a late ack.
        issue(OP_LHU, 32'h0000_5002, 32'h0);
        check("rr_req", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rr_async", {29'd0, busy, mem_req, done}, 32'd0);
        check("rr_addr", mem_addr, 32'd0);
        #1 rst = 1'b0;
        mem_ack = 1'b1;
        step();
        check("rr_no_done", {29'd0, busy, done, mem_req}, 32'd0);
        step();
        check("rr_no_done2", {30'd0, busy, done}, 32'd0);
        mem_ack = 1'b0;

        run_xfer("lbu", OP_LBU, 32'h0000_4001, 32'h0, 32'h0000_F500,
                 32'h0000_4000, 4'b0010, 32'h0, 1'b0, 32'h0000_00F5);
        run_xfer("sb", OP_SB, 32'h0000_6002, 32'h0000_00A5, 32'h0,
                 32'h0000_6000, 4'b0100, 32'hA5A5_A5A5, 1'b1, 32'h0000_00F5);
        run_xfer("sw", OP_SW, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0,
                 32'h0000_7000, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0000_00F5);
        run_xfer("lw", OP_LW, 32'h0000_8000, 32'h0, 32'hCAFE_F00D,
                 32'h0000_8000, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D);
        run_xfer("lh_hi", OP_LH, 32'h0000_9002, 32'h0, 32'h7FFF_8000,
                 32'h0000_9000, 4'b1100, 32'h0, 1'b0, 32'h0000_7FFF);

        issue(6'h3F, 32'h0000_A000, 32'h0);
        check("bad_op", {29'd0, done, err, mem_req}, {29'd0, 1'b1, 1'b1, 1'b0});
        step();
        check("bad_op_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
